// File: rtl/rot_enc_gen.sv
// rot_enc_gen: quadrature rotary-encoder waveform generator.
// Step/direction commands are queued in a small FIFO and each one is played
// out as a full detent (three Gray-coded phases, then rest) on ROT_A/ROT_B.
module rot_enc_gen #(
  parameter int unsigned PHASE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           step_valid,
  input  logic                           step_dir,
  output logic                           step_ready,
  output logic                           ROT_A,
  output logic                           ROT_B,
  output logic                           step_done,
  output logic                           busy,
  output logic [$clog2(DEPTH + 1) - 1:0] pending
);

  localparam int unsigned PEND_W  = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MAX_CNT = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0]  PH_LOAD  = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] FULL_CNT = PEND_W'(DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH1  = 3'd1,
    PH2  = 3'd2,
    PH3  = 3'd3,
    GAP  = 3'd4
  } state_t;

  // Command storage (direction bits only); contents need no reset.
  logic mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_n;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_n;
  logic [PEND_W-1:0] count_q,  count_n;
  logic              ready_q,  ready_n;

  state_t            state_q,  state_n;
  logic [CNT_W-1:0]  cnt_q,    cnt_n;
  logic              dir_q,    dir_n;
  logic [1:0]        rot_q,    rot_n;
  logic              done_q,   done_n;
  logic              busy_q,   busy_n;

  logic              push;
  logic              pop;
  logic              head_dir;

  // Circular pointer advance that also works for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Quadrature code for phase index 0..2; right leads with A, left with B.
  function automatic logic [1:0] phase_code(input logic dir, input logic [1:0] ph);
    logic [1:0] code;
    code = 2'b00;
    case (ph)
      2'd0:    code = dir ? 2'b10 : 2'b01;
      2'd1:    code = 2'b11;
      2'd2:    code = dir ? 2'b01 : 2'b10;
      default: code = 2'b00;
    endcase
    return code;
  endfunction

  // Handshake and pop qualifiers; ready comes from the registered count only.
  always_comb begin
    push     = step_valid & ready_q;
    pop      = (state_q == IDLE) && (count_q != '0);
    head_dir = mem[rd_ptr_q];
  end

  // FIFO bookkeeping: pointers, occupancy and next-cycle ready.
  always_comb begin
    wr_ptr_n = wr_ptr_q;
    rd_ptr_n = rd_ptr_q;
    count_n  = count_q;
    if (push) begin
      wr_ptr_n = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_n = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      count_n = count_q + PEND_W'(1);
    end else if (pop && !push) begin
      count_n = count_q - PEND_W'(1);
    end
    ready_n = (count_n < FULL_CNT);
  end

  // Detent sequencer: next state, phase counter and registered output codes.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    dir_n   = dir_q;
    rot_n   = rot_q;
    done_n  = 1'b0;
    case (state_q)
      IDLE: begin
        rot_n = 2'b00;
        if (pop) begin
          dir_n   = head_dir;
          rot_n   = phase_code(head_dir, 2'd0);
          cnt_n   = PH_LOAD;
          state_n = PH1;
        end
      end
      PH1: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CNT_W'(1);
        end else begin
          rot_n   = phase_code(dir_q, 2'd1);
          cnt_n   = PH_LOAD;
          state_n = PH2;
        end
      end
      PH2: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CNT_W'(1);
        end else begin
          rot_n   = phase_code(dir_q, 2'd2);
          cnt_n   = PH_LOAD;
          state_n = PH3;
        end
      end
      PH3: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CNT_W'(1);
        end else begin
          rot_n   = 2'b00;
          done_n  = 1'b1;
          cnt_n   = GAP_LOAD;
          state_n = GAP;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CNT_W'(1);
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        rot_n   = 2'b00;
      end
    endcase
    busy_n = (state_n != IDLE) || (count_n != '0);
  end

  // Command storage write port.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= step_dir;
    end
  end

  // State and output registers; reset abandons any detent in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      rot_q    <= 2'b00;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_n;
      rd_ptr_q <= rd_ptr_n;
      count_q  <= count_n;
      ready_q  <= ready_n;
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      dir_q    <= dir_n;
      rot_q    <= rot_n;
      done_q   <= done_n;
      busy_q   <= busy_n;
    end
  end

  // Output mapping.
  always_comb begin
    step_ready = ready_q;
    ROT_A      = rot_q[1];
    ROT_B      = rot_q[0];
    step_done  = done_q;
    busy       = busy_q;
    pending    = count_q;
  end

endmodule
